// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_READ_DEF = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_if.sv
// Read, write and reserve bundle between a pipeline and regfile_mp.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_READ = NUM_READ_DEF
);

  logic [NUM_READ*ADDR_W-1:0] read_index;
  logic [NUM_READ*XLEN-1:0]   read_value;
  logic [NUM_READ-1:0]        read_pending;
  logic                       write_enabled;
  logic [ADDR_W-1:0]          write_index;
  logic [XLEN-1:0]            write_value;
  logic                       reserve_enabled;
  logic [ADDR_W-1:0]          reserve_index;
  logic                       ready;

  modport master (
    output read_index,
    output write_enabled,
    output write_index,
    output write_value,
    output reserve_enabled,
    output reserve_index,
    input  read_value,
    input  read_pending,
    input  ready
  );

  modport slave (
    input  read_index,
    input  write_enabled,
    input  write_index,
    input  write_value,
    input  reserve_enabled,
    input  reserve_index,
    output read_value,
    output read_pending,
    output ready
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: bank mux, write bypass,
// zero-register masking and pending lookup.
module regfile_read_port #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] index,
  input  logic [XLEN-1:0]   bank [2**ADDR_W],
  input  logic [2**ADDR_W-1:0] pending,
  input  logic              write_enabled,
  input  logic [ADDR_W-1:0] write_index,
  input  logic [XLEN-1:0]   write_value,
  output logic [XLEN-1:0]   value,
  output logic              pend
);

  logic zero_hit;
  logic byp_hit;

  always_comb begin
    zero_hit = ZERO_REG && (index == '0);
    byp_hit  = BYPASS && write_enabled &&
               (write_index == index);
    value = bank[index];
    pend  = pending[index];
    if (byp_hit) begin
      value = write_value;
      pend  = 1'b0;
    end
    // Contents are undefined until the clear sweep ends.
    if (!run || zero_hit) begin
      value = '0;
      pend  = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with reservation bits and
// a power-on clear sweep that zeroes one entry per cycle.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_READ = NUM_READ_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [XLEN-1:0]   bank_q [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              rsv_ok;
  logic              bank_we;
  logic [ADDR_W-1:0] bank_idx;
  logic [XLEN-1:0]   bank_data;

  logic [NUM_READ*XLEN-1:0] rd_value;
  logic [NUM_READ-1:0]      rd_pend;

  assign run = (state_q == RUN);

  always_comb begin
    wr_ok  = run && bus.write_enabled &&
             !(ZERO_REG && bus.write_index == '0);
    rsv_ok = run && bus.reserve_enabled &&
             !(ZERO_REG && bus.reserve_index == '0);
    bank_we   = !rst && (!run || wr_ok);
    bank_idx  = run ? bus.write_index : clear_ptr_q;
    bank_data = run ? bus.write_value : '0;
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    pending_d   = pending_q;
    if (rst) begin
      state_d     = CLEAR;
      clear_ptr_d = '0;
    end else if (!run) begin
      pending_d[clear_ptr_q] = 1'b0;
      clear_ptr_d = clear_ptr_q + ADDR_W'(1);
      if (&clear_ptr_q) state_d = RUN;
    end else begin
      if (wr_ok)  pending_d[bus.write_index]   = 1'b0;
      // Reservation is applied last so it wins a same-index tie.
      if (rsv_ok) pending_d[bus.reserve_index] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    clear_ptr_q <= clear_ptr_d;
    pending_q   <= pending_d;
    if (bank_we) bank_q[bank_idx] <= bank_data;
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .run           (run),
      .index         (bus.read_index[p*ADDR_W +: ADDR_W]),
      .bank          (bank_q),
      .pending       (pending_q),
      .write_enabled (bus.write_enabled),
      .write_index   (bus.write_index),
      .write_value   (bus.write_value),
      .value         (rd_value[p*XLEN +: XLEN]),
      .pend          (rd_pend[p])
    );
  end

  assign bus.read_value   = rd_value;
  assign bus.read_pending = rd_pend;
  assign bus.ready        = run;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 2-port/32-bit copy and a
// non-bypassing 4-port/64-bit copy driven with the same stimulus.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.XLEN(32), .ADDR_W(5), .NUM_READ(2)) bus_a ();
  regfile_if #(.XLEN(64), .ADDR_W(5), .NUM_READ(4)) bus_b ();

  regfile_mp #(
    .XLEN(32), .ADDR_W(5), .NUM_READ(2),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  regfile_mp #(
    .XLEN(64), .ADDR_W(5), .NUM_READ(4),
    .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wv;
    logic        re;
    logic [4:0]  ridx;
    logic [4:0]  i0;
    logic [4:0]  i1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        p0;
    logic        p1;
    logic [31:0] b0;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] bank_m [32];
  bit          pend_m [32];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we,
                       input logic [4:0] widx,
                       input logic [63:0] wv,
                       input logic re,
                       input logic [4:0] ridx,
                       input logic [4:0] i0, input logic [4:0] i1,
                       input logic [4:0] i2, input logic [4:0] i3);
    bus_a.write_enabled   = we;
    bus_a.write_index     = widx;
    bus_a.write_value     = wv[31:0];
    bus_a.reserve_enabled = re;
    bus_a.reserve_index   = ridx;
    bus_a.read_index      = {i1, i0};
    bus_b.write_enabled   = we;
    bus_b.write_index     = widx;
    bus_b.write_value     = wv;
    bus_b.reserve_enabled = re;
    bus_b.reserve_index   = ridx;
    bus_b.read_index      = {i3, i2, i1, i0};
  endtask

  // Counts cycles with ready low; reads must stay zero meanwhile.
  task automatic count_clear(output int cnt);
    cnt = 0;
    while (bus_a.ready === 1'b0 && cnt < 100) begin
      chk("clr_val_a", {bus_a.read_value, 2'(bus_a.read_pending)}
          == '0 ? 64'd0 : 64'd1, 64'd0);
      chk("clr_val_b", (|bus_b.read_value) | (|bus_b.read_pending)
          ? 64'd1 : 64'd0, 64'd0);
      tick();
      cnt++;
    end
  endtask

  function automatic logic [63:0] exp_val(
    input bit byp, input logic [4:0] idx, input logic we,
    input logic [4:0] widx, input logic [63:0] wv);
    if (idx == 0) return 64'd0;
    if (byp && we && widx == idx) return wv;
    return bank_m[idx];
  endfunction

  function automatic logic exp_pend(
    input bit byp, input logic [4:0] idx, input logic we,
    input logic [4:0] widx);
    if (idx == 0) return 1'b0;
    if (byp && we && widx == idx) return 1'b0;
    return pend_m[idx];
  endfunction

  initial begin
    vec_t        vt [12];
    int          cnt;
    logic        we, re;
    logic [4:0]  widx, ridx;
    logic [63:0] wv;
    logic [4:0]  idx [4];
    logic [63:0] pat;

    vt[0]  = '{1, 3, 32'hDEADBEEF, 0, 0, 3, 3,
               32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    vt[1]  = '{0, 0, 0, 0, 0, 3, 0,
               32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF};
    vt[2]  = '{1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 3,
               0, 32'hDEADBEEF, 0, 0, 0};
    vt[4]  = '{0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 0, 0, 7, 3,
               0, 32'hDEADBEEF, 1, 0, 0};
    vt[6]  = '{1, 7, 32'h5, 1, 7, 7, 7, 5, 5, 0, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 7, 7, 5, 5, 1, 1, 5};
    vt[8]  = '{1, 7, 32'h6, 0, 0, 7, 0, 6, 0, 0, 0, 5};
    vt[9]  = '{0, 0, 0, 0, 0, 7, 7, 6, 6, 0, 0, 6};
    vt[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Power-on reset and clear sweep.
    drive(0, 0, 0, 0, 0, 3, 3, 3, 3);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready_a", 64'(bus_a.ready), 64'd0);
    chk("rst_ready_b", 64'(bus_b.ready), 64'd0);
    rst = 1'b0;
    count_clear(cnt);
    chk("clear_cycles", 64'(cnt), 64'd32);
    chk("ready_a_run", 64'(bus_a.ready), 64'd1);
    chk("ready_b_run", 64'(bus_b.ready), 64'd1);

    // Directed table from a freshly cleared bank.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].we, vt[i].widx, 64'(vt[i].wv),
            vt[i].re, vt[i].ridx,
            vt[i].i0, vt[i].i1, vt[i].i0, vt[i].i0);
      #2;
      chk($sformatf("vec%0d_v0", i),
          64'(bus_a.read_value[31:0]), 64'(vt[i].e0));
      chk($sformatf("vec%0d_v1", i),
          64'(bus_a.read_value[63:32]), 64'(vt[i].e1));
      chk($sformatf("vec%0d_p0", i),
          64'(bus_a.read_pending[0]), 64'(vt[i].p0));
      chk($sformatf("vec%0d_p1", i),
          64'(bus_a.read_pending[1]), 64'(vt[i].p1));
      chk($sformatf("vec%0d_b0", i),
          bus_b.read_value[63:0], 64'(vt[i].b0));
      tick();
    end

    // Wide value seen identically on all four ports.
    pat = 64'hFFFF_0000_FFFF_0000;
    drive(1, 9, pat, 0, 0, 9, 9, 9, 9);
    #2;
    chk("w9_nobyp", bus_b.read_value[63:0], 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 9, 9, 9, 9);
    #2;
    for (int p = 0; p < 4; p++)
      chk($sformatf("w9_b%0d", p),
          bus_b.read_value[p*64 +: 64], pat);
    chk("w9_a0", 64'(bus_a.read_value[31:0]), 64'hFFFF_0000);
    chk("w9_a1", 64'(bus_a.read_value[63:32]), 64'hFFFF_0000);

    // Reset in the middle of a clear restarts the sweep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", 64'(bus_a.ready), 64'd0);
    rst = 1'b0;
    drive(1, 4, 64'hFF, 1, 4, 4, 4, 4, 4);
    count_clear(cnt);
    chk("midrst_cycles", 64'(cnt), 64'd32);
    drive(0, 0, 0, 0, 0, 4, 9, 4, 9);
    #2;
    chk("clr_w4_a", 64'(bus_a.read_value[31:0]), 64'd0);
    chk("clr_p4_a", 64'(bus_a.read_pending[0]), 64'd0);
    chk("clr_w4_b", bus_b.read_value[63:0], 64'd0);
    chk("clr_w9_b", bus_b.read_value[127:64], 64'd0);
    tick();

    // Randomized traffic against the reference model.
    for (int r = 0; r < 32; r++) begin
      bank_m[r] = 64'd0;
      pend_m[r] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      we   = 1'($urandom_range(0, 1));
      widx = 5'($urandom);
      wv   = {$urandom, $urandom};
      re   = ($urandom_range(0, 9) < 3);
      ridx = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom);
      for (int p = 0; p < 4; p++)
        idx[p] = ($urandom_range(0, 2) == 0) ? widx
                                             : 5'($urandom);
      drive(we, widx, wv, re, ridx,
            idx[0], idx[1], idx[2], idx[3]);
      #2;
      for (int p = 0; p < 2; p++) begin
        chk("rnd_a_val", 64'(bus_a.read_value[p*32 +: 32]),
            64'(exp_val(1, idx[p], we, widx, wv) & 64'hFFFF_FFFF));
        chk("rnd_a_pend", 64'(bus_a.read_pending[p]),
            64'(exp_pend(1, idx[p], we, widx)));
      end
      for (int p = 0; p < 4; p++) begin
        chk("rnd_b_val", bus_b.read_value[p*64 +: 64],
            exp_val(0, idx[p], we, widx, wv));
        chk("rnd_b_pend", 64'(bus_b.read_pending[p]),
            64'(exp_pend(0, idx[p], we, widx)));
      end
      tick();
      if (we && widx != 0) begin
        bank_m[widx] = wv;
        pend_m[widx] = 1'b0;
      end
      if (re && ridx != 0) pend_m[ridx] = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
